// File: rtl/agc_io_channels.sv
// AGC I/O channel unit: eight 15-bit channel registers, output-channel FIFO, peripheral input port.
// Optional macro IO_READ_BYPASS_EN forwards a same-cycle core write to the decode-stage read.
module agc_io_channels #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [7:0]  OUT_MASK = 8'hF0
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        IO_write_en,
    input  logic [2:0]  IO_write_sel,
    input  logic [14:0] IO_write_data,
    input  logic [2:0]  IO_read_sel,
    output logic [14:0] IO_read_data,
    input  logic        periph_in_valid,
    input  logic [2:0]  periph_in_chan,
    input  logic [14:0] periph_in_data,
    output logic        periph_in_ready,
    output logic        periph_out_valid,
    output logic [2:0]  periph_out_chan,
    output logic [14:0] periph_out_data,
    input  logic        periph_out_ready,
    output logic        io_stall,
    output logic        io_overflow
);
    localparam int unsigned   PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned   CW      = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [14:0]   chan_q [8];
    logic [14:0]   chan_d [8];
    logic [17:0]   fifo_q [DEPTH];
    logic [17:0]   fifo_d [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          deq, enq_req, enq_ok, in_fire;

    always_comb begin
        periph_in_ready = !(IO_write_en && (IO_write_sel == periph_in_chan));
        in_fire         = periph_in_valid && periph_in_ready;
        deq             = (count_q != '0) && periph_out_ready;
        enq_req         = IO_write_en && OUT_MASK[IO_write_sel];
        // A full FIFO still accepts when the head leaves in the same cycle.
        enq_ok          = enq_req && ((count_q != DEPTH_C) || deq);

        chan_d = chan_q;
        if (in_fire)
            chan_d[periph_in_chan] = periph_in_data;
        if (IO_write_en)
            chan_d[IO_write_sel] = IO_write_data;

        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (enq_ok) begin
            fifo_d[wr_ptr_q] = {IO_write_sel, IO_write_data};
            wr_ptr_d         = wr_ptr_q + PW'(1);
        end
        if (deq)
            rd_ptr_d = rd_ptr_q + PW'(1);

        count_d    = count_q + CW'(enq_ok) - CW'(deq);
        overflow_d = overflow_q || (enq_req && !enq_ok);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < 8; i++)
                chan_q[i] <= '0;
            for (int unsigned i = 0; i < DEPTH; i++)
                fifo_q[i] <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            chan_q     <= chan_d;
            fifo_q     <= fifo_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
`ifdef IO_READ_BYPASS_EN
        if (IO_write_en && (IO_write_sel == IO_read_sel))
            IO_read_data = IO_write_data;
        else
            IO_read_data = chan_q[IO_read_sel];
`else
        IO_read_data = chan_q[IO_read_sel];
`endif
        periph_out_valid                   = (count_q != '0);
        {periph_out_chan, periph_out_data} = fifo_q[rd_ptr_q];
        io_stall                           = (count_q == DEPTH_C);
        io_overflow                        = overflow_q;
    end
endmodule

// File: tb/tb_agc_io_channels.sv
// Scoreboard bench for agc_io_channels: expected FIFO entries queued at issue, checked by a dequeue monitor.
module tb_agc_io_channels;
    logic        clock = 1'b0;
    logic        reset_n;
    logic        IO_write_en;
    logic [2:0]  IO_write_sel;
    logic [14:0] IO_write_data;
    logic [2:0]  IO_read_sel;
    logic [14:0] IO_read_data;
    logic        periph_in_valid;
    logic [2:0]  periph_in_chan;
    logic [14:0] periph_in_data;
    logic        periph_in_ready;
    logic        periph_out_valid;
    logic [2:0]  periph_out_chan;
    logic [14:0] periph_out_data;
    logic        periph_out_ready;
    logic        io_stall;
    logic        io_overflow;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [17:0] exp_q[$];

    agc_io_channels #(.DEPTH(4), .OUT_MASK(8'hF0)) dut (
        .clock(clock), .reset_n(reset_n),
        .IO_write_en(IO_write_en), .IO_write_sel(IO_write_sel), .IO_write_data(IO_write_data),
        .IO_read_sel(IO_read_sel), .IO_read_data(IO_read_data),
        .periph_in_valid(periph_in_valid), .periph_in_chan(periph_in_chan),
        .periph_in_data(periph_in_data), .periph_in_ready(periph_in_ready),
        .periph_out_valid(periph_out_valid), .periph_out_chan(periph_out_chan),
        .periph_out_data(periph_out_data), .periph_out_ready(periph_out_ready),
        .io_stall(io_stall), .io_overflow(io_overflow)
    );

    always #5 clock = ~clock;

    // Dequeue monitor: every accepted head must match the oldest expected entry.
    always @(negedge clock) begin
        if (reset_n && periph_out_valid && periph_out_ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL deq_unexpected: got chan=%0d data=%o, required no entry",
                         periph_out_chan, periph_out_data);
            end else begin
                logic [17:0] e;
                e = exp_q.pop_front();
                if ({periph_out_chan, periph_out_data} !== e) begin
                    n_err++;
                    $display("FAIL deq_entry: got chan=%0d data=%o, required chan=%0d data=%o",
                             periph_out_chan, periph_out_data, e[17:15], e[14:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required $finish");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic rd(input logic [2:0] ch, input logic [14:0] exp, input string name);
        IO_read_sel = ch;
        #1;
        chk(name, 32'(IO_read_data), 32'(exp));
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        cyc();
        cyc();
        reset_n = 1'b1;
        exp_q.delete();
    endtask

    task automatic wr(input logic [2:0] ch, input logic [14:0] d, input logic queued);
        IO_write_en   = 1'b1;
        IO_write_sel  = ch;
        IO_write_data = d;
        if (queued)
            exp_q.push_back({ch, d});
        cyc();
        IO_write_en = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; IO_write_en = 1'b0; IO_write_sel = '0; IO_write_data = '0;
        IO_read_sel = '0; periph_in_valid = 1'b0; periph_in_chan = '0; periph_in_data = '0;
        periph_out_ready = 1'b0;
        do_reset();

        for (int c = 0; c < 8; c++)
            rd(3'(c), 15'o0, "reset_read");
        chk("reset_valid", 32'(periph_out_valid), 0);
        chk("reset_stall", 32'(io_stall), 0);
        chk("reset_overflow", 32'(io_overflow), 0);

        // Single output-channel write, then a non-output write.
        wr(3'd5, 15'o12345, 1'b1);
        chk("enq_valid", 32'(periph_out_valid), 1);
        chk("enq_chan", 32'(periph_out_chan), 5);
        chk("enq_data", 32'(periph_out_data), 32'o12345);
        rd(3'd5, 15'o12345, "ch5_read");
        wr(3'd2, 15'o222, 1'b0);
        rd(3'd2, 15'o222, "ch2_read");
        chk("ch2_noenq_chan", 32'(periph_out_chan), 5);
        chk("ch2_noenq_stall", 32'(io_stall), 0);
        periph_out_ready = 1'b1;
        cyc();
        periph_out_ready = 1'b0;
        chk("drain1_valid", 32'(periph_out_valid), 0);

        // Fill to full, overflow on a fifth write, then drain across the pointer wrap.
        for (int c = 4; c < 8; c++) begin
            wr(3'(c), 15'(15'o100 + c), 1'b1);
            chk("fill_stall", 32'(io_stall), (c == 7) ? 1 : 0);
        end
        chk("full_hold_chan", 32'(periph_out_chan), 4);
        chk("full_overflow0", 32'(io_overflow), 0);
        wr(3'd6, 15'o7777, 1'b0);
        chk("drop_overflow", 32'(io_overflow), 1);
        chk("drop_stall", 32'(io_stall), 1);
        rd(3'd6, 15'o7777, "drop_ch6_read");
        periph_out_ready = 1'b1;
        for (int i = 0; i < 4; i++)
            cyc();
        periph_out_ready = 1'b0;
        chk("drain4_valid", 32'(periph_out_valid), 0);
        chk("drain4_stall", 32'(io_stall), 0);
        chk("overflow_sticky", 32'(io_overflow), 1);

        // Full FIFO with simultaneous enqueue and dequeue.
        do_reset();
        for (int c = 4; c < 8; c++)
            wr(3'(c), 15'(15'o200 + c), 1'b1);
        periph_out_ready = 1'b1;
        wr(3'd7, 15'o7070, 1'b1);
        chk("full_enqdeq_stall", 32'(io_stall), 1);
        chk("full_enqdeq_overflow", 32'(io_overflow), 0);
        chk("full_enqdeq_head", 32'(periph_out_chan), 5);
        for (int i = 0; i < 4; i++)
            cyc();
        periph_out_ready = 1'b0;
        chk("full_enqdeq_empty", 32'(periph_out_valid), 0);

        // Peripheral update collision and retry, then a non-colliding pair.
        periph_in_valid = 1'b1; periph_in_chan = 3'd3; periph_in_data = 15'o777;
        IO_write_en = 1'b1; IO_write_sel = 3'd3; IO_write_data = 15'o1;
        #1;
        chk("collide_ready", 32'(periph_in_ready), 0);
        cyc();
        IO_write_en = 1'b0;
        rd(3'd3, 15'o1, "collide_core_wins");
        chk("retry_ready", 32'(periph_in_ready), 1);
        cyc();
        periph_in_valid = 1'b0;
        rd(3'd3, 15'o777, "retry_commit");
        periph_in_valid = 1'b1; periph_in_chan = 3'd1; periph_in_data = 15'o11;
        IO_write_en = 1'b1; IO_write_sel = 3'd2; IO_write_data = 15'o2;
        #1;
        chk("diff_ready", 32'(periph_in_ready), 1);
        cyc();
        IO_write_en = 1'b0; periph_in_valid = 1'b0;
        rd(3'd1, 15'o11, "diff_periph");
        rd(3'd2, 15'o2, "diff_core");
        chk("periph_noenq", 32'(periph_out_valid), 0);

        // Reset with an entry queued discards it.
        wr(3'd4, 15'o4444, 1'b0);
        chk("pre_reset_valid", 32'(periph_out_valid), 1);
        do_reset();
        chk("midreset_valid", 32'(periph_out_valid), 0);
        rd(3'd4, 15'o0, "midreset_ch4");

        // Write-to-read forwarding on the decode read.
        IO_read_sel = 3'd1;
        IO_write_en = 1'b1; IO_write_sel = 3'd1; IO_write_data = 15'o55;
        #1;
`ifdef IO_READ_BYPASS_EN
        chk("bypass_read", 32'(IO_read_data), 32'o55);
`else
        chk("bypass_read", 32'(IO_read_data), 0);
`endif
        cyc();
        IO_write_en = 1'b0;
        rd(3'd1, 15'o55, "post_write_read");

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
